// File: rtl/i2s_rx_frontend.sv
// rtl/i2s_rx_frontend.sv - I2S receiver front end producing stereo samples in the system clock domain
//
// Purpose: synchronizes an external I2S stream (bclk, lrclk, sdata) into the
// i_clk domain, captures DATA_WIDTH bits per channel MSB first, and presents
// a stereo pair with a one-cycle o_valid strobe. Slot length violations
// produce a one-cycle o_frame_err strobe and the frame is discarded.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_bclk       I2S bit clock (asynchronous)
//   i_lrclk      I2S word select, 0 = left, 1 = right (asynchronous)
//   i_sdata      I2S serial data (asynchronous)
//   o_left       last complete left sample
//   o_right      last complete right sample
//   o_valid      one-cycle pulse, o_left/o_right updated together
//   o_frame_err  one-cycle pulse, slot length violation
module i2s_rx_frontend #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_bclk,
  input  logic                  i_lrclk,
  input  logic                  i_sdata,
  output logic [DATA_WIDTH-1:0] o_left,
  output logic [DATA_WIDTH-1:0] o_right,
  output logic                  o_valid,
  output logic                  o_frame_err
);

  localparam int CW = $clog2(SLOT_WIDTH + 1);
  localparam logic [CW-1:0] DW_C   = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] SLOT_C = CW'(SLOT_WIDTH);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  state_t state;

  logic bclk_s1, bclk_s2, bclk_d;
  logic lr_s1, lr_s2;
  logic sd_s1, sd_s2;
  logic lr_prev;

  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] left_hold;

  logic                  bclk_rise;
  logic                  lr_change;
  logic [CW-1:0]         cnt_inc;
  logic [CW-1:0]         cnt_next;
  logic                  capture;
  logic [DATA_WIDTH-1:0] shreg_next;

  always_comb begin
    bclk_rise  = bclk_s2 & ~bclk_d;
    lr_change  = lr_s2 ^ lr_prev;
    // Saturate so a stalled lrclk while hunting cannot wrap the counter.
    cnt_inc    = (cnt == SLOT_C) ? cnt : cnt + CW'(1);
    cnt_next   = lr_change ? '0 : cnt_inc;
    // The change-edge bit (cnt 0) belongs to the previous slot's padding.
    capture    = (cnt_next >= CW'(1)) && (cnt_next <= DW_C);
    shreg_next = {shreg[DATA_WIDTH-2:0], sd_s2};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bclk_s1     <= 1'b0;
      bclk_s2     <= 1'b0;
      bclk_d      <= 1'b0;
      lr_s1       <= 1'b0;
      lr_s2       <= 1'b0;
      sd_s1       <= 1'b0;
      sd_s2       <= 1'b0;
      lr_prev     <= 1'b0;
      cnt         <= '0;
      shreg       <= '0;
      left_hold   <= '0;
      state       <= HUNT;
      o_left      <= '0;
      o_right     <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      bclk_s1     <= i_bclk;
      bclk_s2     <= bclk_s1;
      bclk_d      <= bclk_s2;
      lr_s1       <= i_lrclk;
      lr_s2       <= lr_s1;
      sd_s1       <= i_sdata;
      sd_s2       <= sd_s1;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;

      if (bclk_rise) begin
        lr_prev <= lr_s2;
        cnt     <= cnt_next;
        if (capture) begin
          shreg <= shreg_next;
        end

        unique case (state)
          HUNT: begin
            // Only a right-to-left change marks a frame start.
            if (lr_change && !lr_s2) begin
              state <= LEFT;
            end
          end
          LEFT: begin
            if (lr_change) begin
              if (cnt >= DW_C) begin
                state <= RIGHT;
              end else begin
                o_frame_err <= 1'b1;
                state       <= HUNT;
              end
            end else if (cnt_inc == SLOT_C) begin
              o_frame_err <= 1'b1;
              state       <= HUNT;
            end else if (cnt_next == DW_C) begin
              left_hold <= shreg_next;
            end
          end
          RIGHT: begin
            if (lr_change) begin
              if (cnt >= DW_C) begin
                state <= LEFT;
              end else begin
                o_frame_err <= 1'b1;
                state       <= HUNT;
              end
            end else if (cnt_inc == SLOT_C) begin
              o_frame_err <= 1'b1;
              state       <= HUNT;
            end else if (cnt_next == DW_C) begin
              o_left  <= left_hold;
              o_right <= shreg_next;
              o_valid <= 1'b1;
            end
          end
          default: begin
            state <= HUNT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_frontend.sv
// tb/tb_i2s_rx_frontend.sv - directed self-checking bench for i2s_rx_frontend
module tb_i2s_rx_frontend;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_bclk = 1'b0;
  logic        i_lrclk = 1'b0;
  logic        i_sdata = 1'b0;
  logic [23:0] o_left;
  logic [23:0] o_right;
  logic        o_valid;
  logic        o_frame_err;

  i2s_rx_frontend #(.DATA_WIDTH(24), .SLOT_WIDTH(32)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_bclk      (i_bclk),
    .i_lrclk     (i_lrclk),
    .i_sdata     (i_sdata),
    .o_left      (o_left),
    .o_right     (o_right),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  int          cyc = 0;
  int          ecount = 0;
  int          both = 0;
  logic [23:0] vq_l[$];
  logic [23:0] vq_r[$];
  int          vq_t[$];

  always @(negedge i_clk) begin
    cyc <= cyc + 1;
    if (o_valid) begin
      vq_l.push_back(o_left);
      vq_r.push_back(o_right);
      vq_t.push_back(cyc);
    end
    if (o_frame_err) ecount <= ecount + 1;
    if (o_valid && o_frame_err) both <= both + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bit clock period of 8 i_clk: data changes while bclk is low.
  task automatic bit_clk(input logic lr, input logic b);
    @(negedge i_clk);
    i_bclk  = 1'b0;
    i_lrclk = lr;
    i_sdata = b;
    repeat (4) @(negedge i_clk);
    i_bclk = 1'b1;
    repeat (3) @(negedge i_clk);
  endtask

  // Bit 0 is the change edge (padding), bits 1..24 the sample MSB first.
  task automatic send_slot(input logic lr, input logic [23:0] d, input int nbits, input logic pad);
    for (int i = 0; i < nbits; i++) begin
      logic b;
      if (i >= 1 && i <= 24) b = d[24-i];
      else b = pad;
      bit_clk(lr, b);
    end
  endtask

  logic [23:0] b2b_l[4];
  logic [23:0] b2b_r[4];
  int          vbase;
  int          ebase;

  initial begin
    b2b_l[0] = 24'h000001; b2b_r[0] = 24'hFFFFFF;
    b2b_l[1] = 24'h800000; b2b_r[1] = 24'h7FFFFF;
    b2b_l[2] = 24'h5A5A5A; b2b_r[2] = 24'hA5A5A5;
    b2b_l[3] = 24'h000000; b2b_r[3] = 24'h000000;

    // Reset with toggling inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      i_bclk  = ~i_bclk;
      i_lrclk = ~i_lrclk;
      i_sdata = (i % 3) == 0;
    end
    @(negedge i_clk);
    i_bclk = 1'b0; i_lrclk = 1'b0; i_sdata = 1'b0;
    i_rst = 1'b0;
    repeat (6) @(negedge i_clk);
    check("rst_left", {8'h0, o_left}, 32'h0);
    check("rst_right", {8'h0, o_right}, 32'h0);
    check("rst_valid", {31'h0, o_valid}, 32'h0);
    check("rst_err", {31'h0, o_frame_err}, 32'h0);
    check("rst_vcount", vq_l.size(), 0);
    check("rst_ecount", ecount, 0);

    // Single frame; the leading 0->1 right slot must be ignored.
    send_slot(1'b1, 24'hDEAD01, 32, 1'b0);
    send_slot(1'b0, 24'h123456, 32, 1'b0);
    send_slot(1'b1, 24'hABCDEF, 32, 1'b0);
    check("single_vcount", vq_l.size(), 1);
    check("single_left", {8'h0, vq_l[0]}, 32'h123456);
    check("single_right", {8'h0, vq_r[0]}, 32'hABCDEF);
    check("single_ecount", ecount, 0);
    check("hold_left", {8'h0, o_left}, 32'h123456);

    // Back-to-back frames with padding bits at 1.
    vbase = vq_l.size();
    for (int f = 0; f < 4; f++) begin
      send_slot(1'b0, b2b_l[f], 32, 1'b1);
      send_slot(1'b1, b2b_r[f], 32, 1'b1);
    end
    check("b2b_vcount", vq_l.size() - vbase, 4);
    for (int f = 0; f < 4; f++) begin
      check($sformatf("b2b_left%0d", f), {8'h0, vq_l[vbase+f]}, {8'h0, b2b_l[f]});
      check($sformatf("b2b_right%0d", f), {8'h0, vq_r[vbase+f]}, {8'h0, b2b_r[f]});
    end
    for (int f = 1; f < 4; f++) begin
      check($sformatf("b2b_gap%0d", f), vq_t[vbase+f] - vq_t[vbase+f-1], 512);
    end
    check("b2b_ecount", ecount, 0);

    // Short left slot: error, no valid, then recovery.
    vbase = vq_l.size();
    ebase = ecount;
    send_slot(1'b0, 24'hFFFFFF, 20, 1'b0);
    send_slot(1'b1, 24'h111111, 32, 1'b0);
    check("short_ecount", ecount - ebase, 1);
    check("short_vcount", vq_l.size() - vbase, 0);
    send_slot(1'b0, 24'h654321, 32, 1'b0);
    send_slot(1'b1, 24'h0F0F0F, 32, 1'b0);
    check("short_rec_vcount", vq_l.size() - vbase, 1);
    check("short_rec_left", {8'h0, vq_l[vbase]}, 32'h654321);
    check("short_rec_right", {8'h0, vq_r[vbase]}, 32'h0F0F0F);

    // Overlong left slot: error at the 33rd bit clock, then recovery.
    vbase = vq_l.size();
    ebase = ecount;
    send_slot(1'b0, 24'hC3C3C3, 40, 1'b0);
    check("long_ecount", ecount - ebase, 1);
    send_slot(1'b1, 24'h222222, 32, 1'b0);
    send_slot(1'b0, 24'h7E57ED, 32, 1'b0);
    send_slot(1'b1, 24'h800001, 32, 1'b0);
    check("long_vcount", vq_l.size() - vbase, 1);
    check("long_rec_left", {8'h0, vq_l[vbase]}, 32'h7E57ED);
    check("long_rec_right", {8'h0, vq_r[vbase]}, 32'h800001);
    check("long_ecount_after", ecount - ebase, 1);

    // Mid-left-slot reset.
    vbase = vq_l.size();
    send_slot(1'b0, 24'h13579B, 10, 1'b0);
    @(negedge i_clk);
    i_bclk = 1'b0;
    repeat (4) @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    check("mrst_left", {8'h0, o_left}, 32'h0);
    check("mrst_right", {8'h0, o_right}, 32'h0);
    send_slot(1'b1, 24'h333333, 32, 1'b0);
    send_slot(1'b0, 24'h2468AC, 32, 1'b0);
    send_slot(1'b1, 24'h9BDF13, 32, 1'b0);
    check("mrst_vcount", vq_l.size() - vbase, 1);
    check("mrst_left_val", {8'h0, vq_l[vbase]}, 32'h2468AC);
    check("mrst_right_val", {8'h0, vq_r[vbase]}, 32'h9BDF13);

    check("valid_err_overlap", both, 0);

    repeat (4) @(negedge i_clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
